seq_divider: RTL

- Multi-cycle signed integer divider in the ALU stage of the datapath.
- Sits between the Y register and bus (operands) and the ZHigh/ZLow registers (results); executes the DIV operation.
- Operand A (dividend) comes from Y; operand B (divisor) comes from the bus.
- Produces quotient (to ZLow/LO) and remainder (to ZHigh/HI). The control step holds until done.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 31 +++
 rtl/seq_divider.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for seq_divider.
package div_pkg;

   localparam int DIV_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } div_state_e;

   // Width of the step counter, which has to hold WIDTH-1.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring compare-subtract-shift step on magnitudes.
// The partial remainder is widened by one bit for the compare so that a
// divisor magnitude of 2^(WIDTH-1) is handled correctly.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] dvs_ext_s;
   logic           ge_s;

   // Shift in the next dividend bit, trial-subtract, and restore when negative.
   always_comb begin
      shifted_s = {rem_i, quo_i[WIDTH-1]};
      dvs_ext_s = {1'b0, dvs_i};
      ge_s      = (shifted_s >= dvs_ext_s);
      if (ge_s) begin
         rem_o = WIDTH'(shifted_s - dvs_ext_s);
      end else begin
         rem_o = shifted_s[WIDTH-1:0];
      end
      quo_o = {quo_i[WIDTH-2:0], ge_s};
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring signed divider (WIDTH+1 cycles per divide).
// Optional macro SEQ_DIVIDER_UNSIGNED_EN adds is_unsigned_i, sampled with
// start_i, selecting unsigned operands with no sign fix-up.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             clock_i,
   input  logic             clear_i,
   input  logic             start_i,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
   input  logic             is_unsigned_i,
`endif
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int CW = cnt_width(WIDTH);

   div_state_e       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder magnitude
   logic [WIDTH-1:0] quo_q, quo_d;        // dividend bits out, quotient bits in
   logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
   logic             sign_quo_q, sign_quo_d;
   logic             sign_rem_q, sign_rem_d;
   logic             zero_q, zero_d;      // current operation divides by zero
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic             uns_s;
   logic             dvd_neg_s;
   logic             dvs_neg_s;
   logic [WIDTH-1:0] dvd_abs_s;
   logic [WIDTH-1:0] dvs_abs_s;
   logic [WIDTH-1:0] step_rem_s;
   logic [WIDTH-1:0] step_quo_s;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
   assign uns_s = is_unsigned_i;
`else
   assign uns_s = 1'b0;
`endif

   // Operand magnitudes; the most-negative value maps to unsigned 2^(WIDTH-1).
   always_comb begin
      dvd_neg_s = dividend_i[WIDTH-1] & ~uns_s;
      dvs_neg_s = divisor_i[WIDTH-1] & ~uns_s;
      if (dvd_neg_s) begin
         dvd_abs_s = {WIDTH{1'b0}} - dividend_i;
      end else begin
         dvd_abs_s = dividend_i;
      end
      if (dvs_neg_s) begin
         dvs_abs_s = {WIDTH{1'b0}} - divisor_i;
      end else begin
         dvs_abs_s = divisor_i;
      end
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem_s),
      .quo_o (step_quo_s)
   );

   // Next-state and datapath control for IDLE -> RUN/FIX -> IDLE.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      sign_quo_d  = sign_quo_q;
      sign_rem_d  = sign_rem_q;
      zero_d      = zero_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               busy_d = 1'b1;
               if (divisor_i == {WIDTH{1'b0}}) begin
                  zero_d     = 1'b1;
                  quo_d      = dividend_i;
                  sign_quo_d = 1'b0;
                  sign_rem_d = 1'b0;
                  state_d    = ST_FIX;
               end else begin
                  zero_d     = 1'b0;
                  quo_d      = dvd_abs_s;
                  dvs_d      = dvs_abs_s;
                  rem_d      = {WIDTH{1'b0}};
                  count_d    = CW'(WIDTH - 1);
                  sign_quo_d = dvd_neg_s ^ dvs_neg_s;
                  sign_rem_d = dvd_neg_s;
                  state_d    = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            rem_d = step_rem_s;
            quo_d = step_quo_s;
            if (count_q == {CW{1'b0}}) begin
               state_d = ST_FIX;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         ST_FIX: begin
            if (zero_q) begin
               quotient_d  = {WIDTH{1'b1}};
               remainder_d = quo_q;
               dbz_d       = 1'b1;
            end else begin
               if (sign_quo_q) begin
                  quotient_d = {WIDTH{1'b0}} - quo_q;
               end else begin
                  quotient_d = quo_q;
               end
               if (sign_rem_q) begin
                  remainder_d = {WIDTH{1'b0}} - rem_q;
               end else begin
                  remainder_d = rem_q;
               end
               dbz_d = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; Clear aborts any operation at once.
   always_ff @(posedge clock_i or posedge clear_i) begin
      if (clear_i) begin
         state_q     <= ST_IDLE;
         count_q     <= {CW{1'b0}};
         rem_q       <= {WIDTH{1'b0}};
         quo_q       <= {WIDTH{1'b0}};
         dvs_q       <= {WIDTH{1'b0}};
         sign_quo_q  <= 1'b0;
         sign_rem_q  <= 1'b0;
         zero_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= {WIDTH{1'b0}};
         remainder_q <= {WIDTH{1'b0}};
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         sign_quo_q  <= sign_quo_d;
         sign_rem_q  <= sign_rem_d;
         zero_q      <= zero_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign quotient_o    = quotient_q;
   assign remainder_o   = remainder_q;
   assign div_by_zero_o = dbz_q;

endmodule
